// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter_if
// Description : Requester-side and controller-side bus bundle of the SDRAM
//               arbiter. The arbiter uses the slave modport. The requesters
//               plus the SDRAM controller use the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_arbiter_if;
    // Port 0: video fetch, read-only
    logic        p0_req;
    logic [23:0] p0_addr;
    logic [15:0] p0_dout;
    logic        p0_ack;

    // Port 1: CPU
    logic        p1_req;
    logic        p1_we;
    logic [23:0] p1_addr;
    logic [15:0] p1_din;
    logic [1:0]  p1_ds;
    logic [15:0] p1_dout;
    logic        p1_ack;

    // Port 2: peripheral DMA
    logic        p2_req;
    logic        p2_we;
    logic [23:0] p2_addr;
    logic [15:0] p2_din;
    logic [1:0]  p2_ds;
    logic [15:0] p2_dout;
    logic        p2_ack;

    // SDRAM controller chipset side
    logic [23:0] sd_addr;
    logic [15:0] sd_din;
    logic [1:0]  sd_ds;
    logic        sd_oe;
    logic        sd_we;
    logic [15:0] sd_dout;

    modport slave (
        input  p0_req, p0_addr,
        output p0_dout, p0_ack,
        input  p1_req, p1_we, p1_addr, p1_din, p1_ds,
        output p1_dout, p1_ack,
        input  p2_req, p2_we, p2_addr, p2_din, p2_ds,
        output p2_dout, p2_ack,
        output sd_addr, sd_din, sd_ds, sd_oe, sd_we,
        input  sd_dout
    );

    modport master (
        output p0_req, p0_addr,
        input  p0_dout, p0_ack,
        output p1_req, p1_we, p1_addr, p1_din, p1_ds,
        input  p1_dout, p1_ack,
        output p2_req, p2_we, p2_addr, p2_din, p2_ds,
        input  p2_dout, p2_ack,
        input  sd_addr, sd_din, sd_ds, sd_oe, sd_we,
        output sd_dout
    );
endinterface
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Shares one single-slot SDRAM controller between three
//               requesters. Port 0 has fixed top priority. Ports 1 and 2
//               alternate round-robin. Tracks the controller's 8-clock slot
//               via sync, issues one grant per slot, returns read data with a
//               one-cycle ack and forces an idle (refresh) slot after
//               REFRESH_MAX consecutive granted slots.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int REFRESH_MAX = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           sync,
    sdram_arbiter_if.slave bus
);

    localparam int         CNT_W      = $clog2(REFRESH_MAX + 1);
    localparam logic [2:0] LAST_PHASE = 3'd7;
    localparam logic [2:0] DONE_PHASE = 3'd6;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_P1   = 2'd2,
        GNT_P2   = 2'd3
    } grant_e;

    logic [2:0]       phase_q,   phase_d;
    logic             aligned_q, aligned_d;
    logic             rr_q,      rr_d;       // 0: port 1 preferred, 1: port 2
    logic [CNT_W-1:0] refresh_q, refresh_d;
    grant_e           grant_q,   grant_d;
    logic [23:0]      sd_addr_q, sd_addr_d;
    logic [15:0]      sd_din_q,  sd_din_d;
    logic [1:0]       sd_ds_q,   sd_ds_d;
    logic             sd_oe_q,   sd_oe_d;
    logic             sd_we_q,   sd_we_d;
    logic [15:0]      p0_dout_q, p0_dout_d;
    logic [15:0]      p1_dout_q, p1_dout_d;
    logic [15:0]      p2_dout_q, p2_dout_d;
    logic             p0_ack_q,  p0_ack_d;
    logic             p1_ack_q,  p1_ack_d;
    logic             p2_ack_q,  p2_ack_d;

    logic   slot_start;
    logic   aligned_now;
    logic   decide;
    logic   refresh_due;
    logic   elig_p0, elig_p1, elig_p2;
    grant_e grant_pick;

    // A new slot opens when sync meets phase 7; the aligning sync itself
    // opens the first slot after reset.
    assign slot_start  = (phase_q == LAST_PHASE) && sync;
    assign aligned_now = aligned_q || sync;
    assign decide      = slot_start && aligned_now;
    assign refresh_due = (refresh_q == CNT_W'(REFRESH_MAX));

    // A port whose ack is showing sits out this decision.
    assign elig_p0 = bus.p0_req && !p0_ack_q;
    assign elig_p1 = bus.p1_req && !p1_ack_q;
    assign elig_p2 = bus.p2_req && !p2_ack_q;

    // Priority pick: forced refresh, then port 0, then round-robin 1/2.
    always_comb begin
        grant_pick = GNT_NONE;
        if (refresh_due) begin
            grant_pick = GNT_NONE;
        end else if (elig_p0) begin
            grant_pick = GNT_P0;
        end else if (!rr_q) begin
            if (elig_p1)      grant_pick = GNT_P1;
            else if (elig_p2) grant_pick = GNT_P2;
        end else begin
            if (elig_p2)      grant_pick = GNT_P2;
            else if (elig_p1) grant_pick = GNT_P1;
        end
    end

    // Next state: phase tracking, completion at phase 6, slot loading at decision.
    always_comb begin
        phase_d   = phase_q;
        aligned_d = aligned_q;
        rr_d      = rr_q;
        refresh_d = refresh_q;
        grant_d   = grant_q;
        sd_addr_d = sd_addr_q;
        sd_din_d  = sd_din_q;
        sd_ds_d   = sd_ds_q;
        sd_oe_d   = sd_oe_q;
        sd_we_d   = sd_we_q;
        p0_dout_d = p0_dout_q;
        p1_dout_d = p1_dout_q;
        p2_dout_d = p2_dout_q;
        p0_ack_d  = 1'b0;
        p1_ack_d  = 1'b0;
        p2_ack_d  = 1'b0;

        // Phase parks at 7 until the controller's sync arrives.
        if (phase_q != LAST_PHASE) begin
            phase_d = phase_q + 3'd1;
        end else if (sync) begin
            phase_d   = 3'd0;
            aligned_d = 1'b1;
        end

        // Read data is valid from the controller at the end of phase 6.
        if (phase_q == DONE_PHASE) begin
            case (grant_q)
                GNT_P0: begin
                    p0_ack_d  = 1'b1;
                    p0_dout_d = bus.sd_dout;
                end
                GNT_P1: begin
                    p1_ack_d = 1'b1;
                    if (!sd_we_q) p1_dout_d = bus.sd_dout;
                end
                GNT_P2: begin
                    p2_ack_d = 1'b1;
                    if (!sd_we_q) p2_dout_d = bus.sd_dout;
                end
                default: ;
            endcase
        end

        if (decide) begin
            grant_d   = grant_pick;
            refresh_d = (grant_pick == GNT_NONE) ? '0 : refresh_q + CNT_W'(1);
            case (grant_pick)
                GNT_P0: begin
                    sd_addr_d = bus.p0_addr;
                    sd_ds_d   = 2'b11;
                    sd_oe_d   = 1'b1;
                    sd_we_d   = 1'b0;
                end
                GNT_P1: begin
                    sd_addr_d = bus.p1_addr;
                    sd_din_d  = bus.p1_din;
                    sd_ds_d   = bus.p1_ds;
                    sd_oe_d   = !bus.p1_we;
                    sd_we_d   = bus.p1_we;
                    rr_d      = 1'b1;
                end
                GNT_P2: begin
                    sd_addr_d = bus.p2_addr;
                    sd_din_d  = bus.p2_din;
                    sd_ds_d   = bus.p2_ds;
                    sd_oe_d   = !bus.p2_we;
                    sd_we_d   = bus.p2_we;
                    rr_d      = 1'b0;
                end
                default: begin
                    sd_oe_d = 1'b0;
                    sd_we_d = 1'b0;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q   <= LAST_PHASE;
            aligned_q <= 1'b0;
            rr_q      <= 1'b0;
            refresh_q <= '0;
            grant_q   <= GNT_NONE;
            sd_addr_q <= 24'h000000;
            sd_din_q  <= 16'h0000;
            sd_ds_q   <= 2'b00;
            sd_oe_q   <= 1'b0;
            sd_we_q   <= 1'b0;
            p0_dout_q <= 16'h0000;
            p1_dout_q <= 16'h0000;
            p2_dout_q <= 16'h0000;
            p0_ack_q  <= 1'b0;
            p1_ack_q  <= 1'b0;
            p2_ack_q  <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            aligned_q <= aligned_d;
            rr_q      <= rr_d;
            refresh_q <= refresh_d;
            grant_q   <= grant_d;
            sd_addr_q <= sd_addr_d;
            sd_din_q  <= sd_din_d;
            sd_ds_q   <= sd_ds_d;
            sd_oe_q   <= sd_oe_d;
            sd_we_q   <= sd_we_d;
            p0_dout_q <= p0_dout_d;
            p1_dout_q <= p1_dout_d;
            p2_dout_q <= p2_dout_d;
            p0_ack_q  <= p0_ack_d;
            p1_ack_q  <= p1_ack_d;
            p2_ack_q  <= p2_ack_d;
        end
    end

    assign bus.sd_addr = sd_addr_q;
    assign bus.sd_din  = sd_din_q;
    assign bus.sd_ds   = sd_ds_q;
    assign bus.sd_oe   = sd_oe_q;
    assign bus.sd_we   = sd_we_q;
    assign bus.p0_dout = p0_dout_q;
    assign bus.p1_dout = p1_dout_q;
    assign bus.p2_dout = p2_dout_q;
    assign bus.p0_ack  = p0_ack_q;
    assign bus.p1_ack  = p1_ack_q;
    assign bus.p2_ack  = p2_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Self-checking bench for sdram_arbiter. Stimulus queues the
//               expected slot contents and acks; one monitor compares them
//               against what the arbiter presents at each slot start and ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int REFRESH_MAX = 4;

    typedef struct packed {
        logic        oe;
        logic        we;
        logic [23:0] addr;
        logic [15:0] din;
        logic [1:0]  ds;
    } slot_t;

    typedef struct packed {
        logic [1:0]  port;
        logic [15:0] data;
    } ack_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic sync    = 1'b0;

    int checks = 0;
    int errors = 0;
    int slot_ph = 7;

    slot_t slot_q[$];
    ack_t  ack_q[$];

    sdram_arbiter_if bus ();

    sdram_arbiter #(.REFRESH_MAX(REFRESH_MAX)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sync    (sync),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Controller's read data per address; only driven during phase 6.
    function automatic logic [15:0] sd_mem(input logic [23:0] a);
        case (a)
            24'h001234: return 16'hBEEF;
            24'h000100: return 16'h1001;
            24'h000200: return 16'h2002;
            24'h000300: return 16'h3003;
            24'h000400: return 16'h4004;
            default:    return 16'h0BAD;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push_rd(input logic [23:0] a, input logic [1:0] ds);
        slot_q.push_back('{oe: 1'b1, we: 1'b0, addr: a, din: 16'h0000, ds: ds});
    endfunction

    function automatic void push_wr(input logic [23:0] a, input logic [15:0] d, input logic [1:0] ds);
        slot_q.push_back('{oe: 1'b0, we: 1'b1, addr: a, din: d, ds: ds});
    endfunction

    function automatic void push_none();
        slot_q.push_back('{oe: 1'b0, we: 1'b0, addr: 24'h0, din: 16'h0, ds: 2'b00});
    endfunction

    function automatic void push_ack(input logic [1:0] p, input logic [15:0] d);
        ack_q.push_back('{port: p, data: d});
    endfunction

    task automatic wait_ph(input int ph);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (slot_ph != ph && n < 100);
        if (slot_ph != ph) begin
            checks++;
            errors++;
            $display("FAIL wait_phase: got phase %0d expected %0d", slot_ph, ph);
        end
    endtask

    // Sync pulse every 8 clocks.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt = (cnt + 1) % 8;
            sync = (cnt == 0);
        end
    end

    // Slot phase as seen by the controller.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n)          slot_ph = 7;
            else if (slot_ph == 7) begin
                if (sync) slot_ph = 0;
            end else               slot_ph = slot_ph + 1;
        end
    end

    // Controller read data, valid during phase 6 only.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && slot_ph == 6) bus.sd_dout = sd_mem(bus.sd_addr);
            else                         bus.sd_dout = 16'hFFFF;
        end
    end

    task automatic ack_seen(input logic [1:0] p, input logic [15:0] d);
        ack_t e;
        if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got port %0d data %h expected no ack", p, d);
        end else begin
            e = ack_q.pop_front();
            chk("ack_port", 32'(p), 32'(e.port));
            chk("ack_dout", 32'(d), 32'(e.data));
        end
    endtask

    // Monitor: slot contents at phase 0, their stability through phase 7, and acks.
    initial begin
        slot_t e;
        slot_t cap;
        logic  cap_valid;
        cap_valid = 1'b0;
        cap       = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cap_valid = 1'b0;
            end else if (slot_ph == 0) begin
                if (slot_q.size() != 0) begin
                    e = slot_q.pop_front();
                    chk("slot_oe", 32'(bus.sd_oe), 32'(e.oe));
                    chk("slot_we", 32'(bus.sd_we), 32'(e.we));
                    if (e.oe || e.we) begin
                        chk("slot_addr", 32'(bus.sd_addr), 32'(e.addr));
                        chk("slot_ds", 32'(bus.sd_ds), 32'(e.ds));
                    end
                    if (e.we) chk("slot_din", 32'(bus.sd_din), 32'(e.din));
                end else if (bus.sd_oe || bus.sd_we) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got oe=%b we=%b addr=%h expected idle",
                             bus.sd_oe, bus.sd_we, bus.sd_addr);
                end
                cap       = '{oe: bus.sd_oe, we: bus.sd_we, addr: bus.sd_addr, din: bus.sd_din, ds: bus.sd_ds};
                cap_valid = bus.sd_oe || bus.sd_we;
            end else if (cap_valid) begin
                chk("slot_stable", {bus.sd_oe, bus.sd_we, bus.sd_ds, bus.sd_addr[11:0], bus.sd_din},
                    {cap.oe, cap.we, cap.ds, cap.addr[11:0], cap.din});
            end
            if (bus.p0_ack === 1'b1) ack_seen(2'd0, bus.p0_dout);
            if (bus.p1_ack === 1'b1) ack_seen(2'd1, bus.p1_dout);
            if (bus.p2_ack === 1'b1) ack_seen(2'd2, bus.p2_dout);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int n;
        bus.p0_req = 1'b0; bus.p0_addr = 24'h0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 24'h0; bus.p1_din = 16'h0; bus.p1_ds = 2'b00;
        bus.p2_req = 1'b0; bus.p2_we = 1'b0; bus.p2_addr = 24'h0; bus.p2_din = 16'h0; bus.p2_ds = 2'b00;

        // Reset with p0 already requesting; nothing granted before the first sync.
        reset_n     = 1'b0;
        bus.p0_req  = 1'b1;
        bus.p0_addr = 24'h001234;
        push_rd(24'h001234, 2'b11);
        push_ack(2'd0, 16'hBEEF);
        repeat (4) @(posedge clk);
        #2;
        chk("rst_acks", {bus.p0_ack, bus.p1_ack, bus.p2_ack}, 3'b000);
        chk("rst_p0_dout", bus.p0_dout, 16'h0000);
        chk("rst_p1_dout", bus.p1_dout, 16'h0000);
        chk("rst_p2_dout", bus.p2_dout, 16'h0000);
        chk("rst_sd_ctrl", {bus.sd_oe, bus.sd_we, bus.sd_ds}, 4'b0000);
        chk("rst_sd_addr", bus.sd_addr, 24'h000000);
        chk("rst_sd_din", bus.sd_din, 16'h0000);
        reset_n = 1'b1;
        n = 0;
        while (slot_ph != 0 && n < 40) begin
            chk("oe_before_sync", bus.sd_oe, 1'b0);
            @(posedge clk);
            #2;
            n++;
        end
        if (slot_ph != 0) begin
            checks++;
            errors++;
            $display("FAIL first_sync: got phase %0d expected 0", slot_ph);
        end
        chk("oe_first_slot", bus.sd_oe, 1'b1);
        wait_ph(7);
        chk("p0_ack_phase7", bus.p0_ack, 1'b1);
        bus.p0_req = 1'b0;
        @(posedge clk);
        #2;
        chk("p0_ack_pulse", bus.p0_ack, 1'b0);
        chk("p0_dout_held", bus.p0_dout, 16'hBEEF);

        // p1/p2 held round-robin, p0 joins; refresh slot after every 4 grants.
        wait_ph(1);
        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 24'h000100; bus.p1_ds = 2'b10;
        bus.p2_req = 1'b1; bus.p2_we = 1'b0; bus.p2_addr = 24'h000200; bus.p2_ds = 2'b11;
        push_rd(24'h000100, 2'b10); push_ack(2'd1, 16'h1001);
        push_rd(24'h000200, 2'b11); push_ack(2'd2, 16'h2002);
        push_rd(24'h000100, 2'b10); push_ack(2'd1, 16'h1001);
        push_rd(24'h000200, 2'b11); push_ack(2'd2, 16'h2002);
        push_none();
        push_rd(24'h000300, 2'b11); push_ack(2'd0, 16'h3003);
        push_rd(24'h000100, 2'b10); push_ack(2'd1, 16'h1001);
        push_rd(24'h000300, 2'b11); push_ack(2'd0, 16'h3003);
        push_rd(24'h000200, 2'b11); push_ack(2'd2, 16'h2002);
        push_none();
        push_rd(24'h000300, 2'b11); push_ack(2'd0, 16'h3003);
        push_rd(24'h000100, 2'b10); push_ack(2'd1, 16'h1001);
        repeat (4) wait_ph(0);
        wait_ph(1);
        bus.p0_req  = 1'b1;
        bus.p0_addr = 24'h000300;
        repeat (8) wait_ph(0);
        wait_ph(7);
        bus.p0_req = 1'b0; bus.p1_req = 1'b0; bus.p2_req = 1'b0;

        // p0 alone: served every other slot; idle slots keep the refresh count from building.
        wait_ph(1);
        bus.p0_req  = 1'b1;
        bus.p0_addr = 24'h000400;
        for (int i = 0; i < 4; i++) begin
            push_rd(24'h000400, 2'b11); push_ack(2'd0, 16'h4004);
            push_none();
        end
        push_rd(24'h000400, 2'b11); push_ack(2'd0, 16'h4004);
        repeat (9) wait_ph(0);
        wait_ph(7);
        bus.p0_req = 1'b0;

        // p1 write: data strobes and we held, p1_dout keeps the last read value.
        wait_ph(1);
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 24'h00ABCD;
        bus.p1_din = 16'h5A5A; bus.p1_ds = 2'b01;
        push_wr(24'h00ABCD, 16'h5A5A, 2'b01);
        push_ack(2'd1, 16'h1001);
        wait_ph(0);
        wait_ph(7);
        bus.p1_req = 1'b0;
        @(posedge clk);
        #2;
        chk("p1_dout_after_write", bus.p1_dout, 16'h1001);

        // Reset in the middle of a p2 read: no ack, re-served after realignment.
        wait_ph(1);
        bus.p2_req = 1'b1; bus.p2_we = 1'b0; bus.p2_addr = 24'h000200; bus.p2_ds = 2'b11;
        push_rd(24'h000200, 2'b11);
        wait_ph(0);
        wait_ph(3);
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        chk("oe_after_mid_reset", bus.sd_oe, 1'b0);
        chk("p2_dout_after_reset", bus.p2_dout, 16'h0000);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        push_rd(24'h000200, 2'b11);
        push_ack(2'd2, 16'h2002);
        n = 0;
        while (slot_ph != 0 && n < 40) begin
            chk("no_p2_ack_after_reset", bus.p2_ack, 1'b0);
            @(posedge clk);
            #2;
            n++;
        end
        if (slot_ph != 0) begin
            checks++;
            errors++;
            $display("FAIL realign: got phase %0d expected 0", slot_ph);
        end
        wait_ph(7);
        bus.p2_req = 1'b0;
        wait_ph(1);

        chk("slot_queue_empty", slot_q.size(), 0);
        chk("ack_queue_empty", ack_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
